ppu_vsq_quant: RTL
==================

# ppu_vsq_quant

Parametrised post-processing unit with a per-block VSQ buffer. It accepts rows of `LANES` signed accumulator partial sums and applies fixed-point scale, bias, ReLU and saturation to each row. Rows are buffered per block while the block's running maximum is tracked; an iterative divider then computes `255/max`, and the buffered rows stream out as unsigned INT8 vectors together with the block maximum. The block sits between the systolic-array accumulator output and the activation/softmax stage, and replaces the fixed 16-lane PPU path with a valid/ready handshaked, depth-configurable one.

## Interface
- `LANES`, 16, lanes per row.
- `ACC_W`, 24, signed partial-sum width per lane.
- `VSQ_W`, 18, unsigned buffered width per lane.
- `DEPTH`, 16, maximum rows per block (≥2).
- `SCALE_W`, 16, unsigned scale width, Q(`SCALE_W-SCALE_FRAC`).`SCALE_FRAC`.
- `SCALE_FRAC`, 12, scale fraction bits.
- `BIAS_W`, 8, signed bias width.
- `RECIP_FRAC`, 13, reciprocal fraction bits. `QW = 8+RECIP_FRAC`.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `scale` in `SCALE_W`: sampled on each input handshake.
- `bias` in `BIAS_W`: sampled on each input handshake.
- `in_valid` in 1, `in_ready` out 1, `in_last` in 1, `in_data` in `LANES*ACC_W`: input row stream; lane *i* occupies bits [i*ACC_W +: ACC_W].
- `out_valid` out 1, `out_ready` in 1, `out_last` out 1.
- `out_data` out `LANES*8`: quantised row.
- `out_max` out `VSQ_W`: block maximum, used as the dequant scale.
- `busy` out 1: high while in DIV or DRAIN.

## Operation
- States: FILL → DIV → DRAIN → FILL. Reset state is FILL.
- Per lane on input handshake:
  - `s = (x*scale) >>> SCALE_FRAC`, signed, full-width product.
  - `b = s + sext(bias)`.
  - `r = b<0 ? 0 : b`.
  - `v = min(r, 2^VSQ_W-1)`.
  - `v` is written to `buf[wr_ptr]`.
- Running max: `max <= max(max, all v of the row)`. This includes the current row in the same edge. `max` clears to 0 on entry to FILL.
- FILL:
  - `in_ready=1`.
  - Handshake = `in_valid & in_ready`.
  - Leave FILL on a handshake with `in_last=1`, or on the handshake of row `DEPTH` (implicit last).
  - Row count `n` is latched, 1..`DEPTH`.
- DIV:
  - `in_ready=0`.
  - Restoring divider computes `recip = floor((255<<RECIP_FRAC)/max)`, one quotient bit per cycle, `QW` cycles.
  - If `max==0`: `recip=0` and DIV still takes `QW` cycles.
- DRAIN:
  - `out_valid=1`.
  - Row `k`: `q = (buf[k]*recip) >> RECIP_FRAC`, clamped to 255.
  - `out_last = (k==n-1)`; `out_max = max`.
  - `k` advances only on `out_valid & out_ready`.
  - The handshake with `out_last` returns to FILL.
- `in_valid` outside FILL is ignored: no write and no state change.
- `scale`/`bias` may change per row.

## Timing
- Reset values:
  - `in_ready=1`, `out_valid=0`, `out_last=0`, `out_data=0`, `out_max=0`, `busy=0`.
  - Pointers, `max`, `recip` and the divider are cleared.
  - Buffer contents are not reset.
- Input path: one row per cycle. There is no input bubble inside a block.
- Last-row handshake at edge T:
  - `in_ready` is low from T.
  - `busy` is high from T.
  - `out_valid` rises at edge T+QW+1.
- Output: one row per cycle while `out_ready=1`. `out_data`, `out_last` and `out_max` stay stable while `out_valid & !out_ready`.
- After the final output handshake at edge U: `in_ready=1` and `out_valid=0` from U. The next block's first row can be accepted in the cycle after U.
- `in_data`/`out_data` have no combinational path to ready signals. `in_ready` depends only on state.
- Reset mid-operation: all state returns to the reset values asynchronously and any partial block is discarded.

## Configuration
- `PPU_VSQ_ROUND_EN`:
  - Defined: quantisation is round-half-up, `q = (buf*recip + 2^(RECIP_FRAC-1)) >> RECIP_FRAC`, then clamped to 255.
  - Undefined: truncation as in Operation.
  - The divider and all other paths are identical in both cases.

## Structure
- Package `ppu_vsq_pkg`:
  - State enum (FILL, DIV, DRAIN).
  - Default parameter constants.
  - `QW` derivation.
  - Saturate/clamp helper functions.
- Sub-module `ppu_recip_div`: parametrised iterative restoring divider.
  - `start`, dividend `255<<RECIP_FRAC`, divisor `VSQ_W` bits.
  - Outputs `done` and `quot` (`QW` bits).
  - Divide-by-zero yields 0.

## Test plan
- One row `in_last=1`, `scale=0x1000`, `bias=0`, lane0=1000, others=500 → `recip=2088`, `out_data` lane0=254 (255 with ROUND_EN), others=127, `out_max=1000`, `out_last=1`; `out_valid` rises exactly QW+1 edges after accept.
- Lane=-100, `bias=5` → `v=0`, `q=0`. Lane=2^20, `scale=0x1000` → `v=262143` (saturation).
- 16 rows without `in_last` → `in_ready` low after the 16th handshake; exactly 16 outputs, `out_last` on the 16th only.
- All-zero block of 3 rows → `recip=0`; 3 outputs of all zeros, `out_max=0`.
- `out_ready` held low 3 cycles mid-drain → `out_data`/`out_last` unchanged; no row skipped or duplicated.
- `rst_n` pulsed low during DIV and during DRAIN → all outputs at reset values immediately; next block processes correctly with `max` from that block only.

Source files
------------

// File: rtl/ppu_vsq_pkg.sv
// Shared types, default parameters and helpers for the VSQ post-processing unit.
// Optional feature macro: PPU_VSQ_ROUND_EN (round-half-up quantisation).
package ppu_vsq_pkg;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_DIV,
        ST_DRAIN
    } state_t;

    localparam int DEF_LANES      = 16;
    localparam int DEF_ACC_W      = 24;
    localparam int DEF_VSQ_W      = 18;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_SCALE_W    = 16;
    localparam int DEF_SCALE_FRAC = 12;
    localparam int DEF_BIAS_W     = 8;
    localparam int DEF_RECIP_FRAC = 13;

    // The reciprocal of 255/max keeps eight integer bits above its fraction.
    function automatic int calc_qw(input int recip_frac);
        return 8 + recip_frac;
    endfunction

    localparam int DEF_QW = calc_qw(DEF_RECIP_FRAC);

    // Clamp a signed value into [0, 2^width-1]; width must not exceed 32.
    function automatic logic [31:0] sat_unsigned(input logic signed [63:0] val, input int width);
        logic signed [63:0] limit;
        limit = (64'sd1 <<< width) - 64'sd1;
        if (val < 0)
            return '0;
        else if (val > limit)
            return limit[31:0];
        else
            return val[31:0];
    endfunction

    function automatic logic [7:0] clamp_u8(input logic [63:0] val);
        return (val > 64'd255) ? 8'hFF : val[7:0];
    endfunction

endpackage

// File: rtl/ppu_recip_div.sv
// Iterative restoring divider: quot = floor((255 << RECIP_FRAC) / divisor), one bit per cycle.
// A zero divisor yields a zero quotient after the same number of cycles.
module ppu_recip_div
    import ppu_vsq_pkg::*;
#(
    parameter int VSQ_W      = DEF_VSQ_W,
    parameter int RECIP_FRAC = DEF_RECIP_FRAC
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [VSQ_W-1:0]                 divisor,
    output logic                             done,
    output logic [calc_qw(RECIP_FRAC)-1:0]   quot
);

    localparam int QW    = calc_qw(RECIP_FRAC);
    localparam int CNT_W = $clog2(QW + 1);
    localparam logic [QW-1:0] DIVIDEND = QW'(255) << RECIP_FRAC;

    logic [VSQ_W-1:0] rem;
    logic [VSQ_W-1:0] dvsr;
    logic [QW-1:0]    shreg;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             zero;
    logic [VSQ_W:0]   trial;
    logic [VSQ_W:0]   diff;
    logic             fits;

    // shreg shifts dividend bits out of the top while quotient bits enter at the bottom.
    assign trial = {rem, shreg[QW-1]};
    assign diff  = trial - {1'b0, dvsr};
    assign fits  = (trial >= {1'b0, dvsr});
    assign quot  = zero ? '0 : shreg;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem     <= '0;
            dvsr    <= '0;
            shreg   <= '0;
            cnt     <= '0;
            running <= 1'b0;
            zero    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem     <= '0;
                dvsr    <= divisor;
                shreg   <= DIVIDEND;
                cnt     <= CNT_W'(QW);
                running <= 1'b1;
                zero    <= (divisor == '0);
            end else if (running) begin
                rem   <= fits ? diff[VSQ_W-1:0] : trial[VSQ_W-1:0];
                shreg <= {shreg[QW-2:0], fits};
                cnt   <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ppu_vsq_quant.sv
// Post-processing unit: scale/bias/ReLU/saturate rows into a block buffer, then requantise to INT8
// against the block maximum. Defining PPU_VSQ_ROUND_EN selects round-half-up instead of truncation.
module ppu_vsq_quant
    import ppu_vsq_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int VSQ_W      = DEF_VSQ_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int SCALE_W    = DEF_SCALE_W,
    parameter int SCALE_FRAC = DEF_SCALE_FRAC,
    parameter int BIAS_W     = DEF_BIAS_W,
    parameter int RECIP_FRAC = DEF_RECIP_FRAC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SCALE_W-1:0]     scale,
    input  logic [BIAS_W-1:0]      bias,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic [LANES*ACC_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [LANES*8-1:0]     out_data,
    output logic [VSQ_W-1:0]       out_max,
    output logic                   busy
);

    localparam int QW    = calc_qw(RECIP_FRAC);
    localparam int PTR_W = $clog2(DEPTH);

    state_t                   state;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         last_idx;
    logic [PTR_W-1:0]         rd_sel;
    logic [VSQ_W-1:0]         max_q;
    logic [VSQ_W-1:0]         max_next;
    logic [LANES*VSQ_W-1:0]   row_v;
    logic [LANES*VSQ_W-1:0]   rd_row;
    logic [LANES*8-1:0]       q_row;
    logic [LANES*VSQ_W-1:0]   row_buf [DEPTH];
    logic                     in_fire;
    logic                     block_end;
    logic                     div_done;
    logic [QW-1:0]            recip;

    function automatic logic [VSQ_W-1:0] lane_vsq(input logic [ACC_W-1:0] x,
                                                  input logic [SCALE_W-1:0] sc,
                                                  input logic [BIAS_W-1:0] bi);
        logic signed [63:0] xe;
        logic signed [63:0] se;
        logic signed [63:0] be;
        logic signed [63:0] b;
        logic [31:0]        sat;
        xe  = {{(64-ACC_W){x[ACC_W-1]}}, x};
        se  = {{(64-SCALE_W){1'b0}}, sc};
        be  = {{(64-BIAS_W){bi[BIAS_W-1]}}, bi};
        b   = ((xe * se) >>> SCALE_FRAC) + be;
        sat = sat_unsigned(b, VSQ_W);
        return sat[VSQ_W-1:0];
    endfunction

    function automatic logic [7:0] quant(input logic [VSQ_W-1:0] v, input logic [QW-1:0] r);
        logic [63:0] p;
        p = {{(64-VSQ_W){1'b0}}, v} * {{(64-QW){1'b0}}, r};
`ifdef PPU_VSQ_ROUND_EN
        p = p + (64'd1 << (RECIP_FRAC - 1));
`endif
        return clamp_u8(p >> RECIP_FRAC);
    endfunction

    assign in_ready  = (state == ST_FILL);
    assign busy      = (state != ST_FILL);
    assign in_fire   = in_valid & in_ready;
    assign block_end = in_fire & (in_last | (wr_ptr == PTR_W'(DEPTH - 1)));

    // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
    always_comb begin
        row_v    = '0;
        max_next = max_q;
        for (int i = 0; i < LANES; i++) begin
            row_v[i*VSQ_W +: VSQ_W] = lane_vsq(in_data[i*ACC_W +: ACC_W], scale, bias);
            if (row_v[i*VSQ_W +: VSQ_W] > max_next)
                max_next = row_v[i*VSQ_W +: VSQ_W];
        end
    end

    // Prefetch the row that will be presented after the current output handshake.
    always_comb begin
        rd_sel = (state == ST_DRAIN && !out_last) ? rd_ptr + PTR_W'(1) : '0;
        rd_row = row_buf[rd_sel];
        q_row  = '0;
        for (int i = 0; i < LANES; i++)
            q_row[i*8 +: 8] = quant(rd_row[i*VSQ_W +: VSQ_W], recip);
    end

    // NOTE: the row buffer has no reset; it is always written before it is read within a block.
    always_ff @(posedge clk) begin
        if (in_fire)
            row_buf[wr_ptr] <= row_v;
    end

    ppu_recip_div #(
        .VSQ_W      (VSQ_W),
        .RECIP_FRAC (RECIP_FRAC)
    ) u_div (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (block_end),
        .divisor (max_next),
        .done    (div_done),
        .quot    (recip)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            last_idx  <= '0;
            max_q     <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_max   <= '0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (in_fire) begin
                        max_q <= max_next;
                        if (block_end) begin
                            state    <= ST_DIV;
                            last_idx <= wr_ptr;
                            wr_ptr   <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        state     <= ST_DRAIN;
                        rd_ptr    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= q_row;
                        out_last  <= (last_idx == '0);
                        out_max   <= max_q;
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= ST_FILL;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            max_q     <= '0;
                        end else begin
                            rd_ptr   <= rd_ptr + PTR_W'(1);
                            out_data <= q_row;
                            out_last <= (rd_ptr + PTR_W'(1) == last_idx);
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule
